// File: rtl/concat_serializer.sv
// Parallel-to-serial stage for concatenated words: valid/ready input, one bit per clock out,
// with frame_start/frame_end markers. Define CONCAT_SER_PARITY_EN to append an even-parity bit.
module concat_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int            CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

`ifdef CONCAT_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sr, sr_nxt, sr_shift;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              final_cycle;
    logic              accept;
    logic              sout_nxt, frame_start_nxt, frame_end_nxt, busy_nxt;
`ifdef CONCAT_SER_PARITY_EN
    logic              par, par_nxt;
`endif

    function automatic logic out_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

`ifdef CONCAT_SER_PARITY_EN
    assign final_cycle = (state == PARITY);
`else
    assign final_cycle = (state == SHIFT) && (cnt == LAST);
`endif

    // Ready is combinational so a word can be taken on the last frame cycle with no gap.
    assign din_ready = !rst && ((state == IDLE) || final_cycle);
    assign accept    = din_valid && din_ready;
    assign sr_shift  = MSB_FIRST ? {sr[DATA_W-2:0], 1'b0} : {1'b0, sr[DATA_W-1:1]};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
`ifdef CONCAT_SER_PARITY_EN
        par_nxt   = par;
`endif
        unique case (state)
            IDLE: ;
            SHIFT: begin
                sr_nxt  = sr_shift;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
`ifdef CONCAT_SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef CONCAT_SER_PARITY_EN
            PARITY: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase

        // An accept only happens in IDLE or on the final cycle, so it overrides the above.
        if (accept) begin
            state_nxt = SHIFT;
            sr_nxt    = din;
            cnt_nxt   = '0;
`ifdef CONCAT_SER_PARITY_EN
            par_nxt   = ^din;
`endif
        end
    end

    // Outputs are decoded from the next state so they can be registered without adding latency.
    always_comb begin
        busy_nxt        = (state_nxt != IDLE);
        frame_start_nxt = (state_nxt == SHIFT) && (cnt_nxt == '0);
        sout_nxt        = 1'b0;
        if (state_nxt == SHIFT) sout_nxt = out_bit(sr_nxt);
`ifdef CONCAT_SER_PARITY_EN
        if (state_nxt == PARITY) sout_nxt = par_nxt;
        frame_end_nxt   = (state_nxt == PARITY);
`else
        frame_end_nxt   = (state_nxt == SHIFT) && (cnt_nxt == LAST);
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
`ifdef CONCAT_SER_PARITY_EN
            par         <= 1'b0;
`endif
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            cnt         <= cnt_nxt;
`ifdef CONCAT_SER_PARITY_EN
            par         <= par_nxt;
`endif
            sout        <= sout_nxt;
            sout_valid  <= busy_nxt;
            frame_start <= frame_start_nxt;
            frame_end   <= frame_end_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_concat_serializer.sv
// Bench for concat_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared each cycle against a queue-of-frame-bits reference model.
module tb_concat_serializer;

`ifdef CONCAT_SER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } fbit_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       m_ready, m_sout, m_valid, m_start, m_end, m_busy;
    logic       l_ready, l_sout, l_valid, l_start, l_end, l_busy;

    int total = 0;
    int bad   = 0;

    fbit_t qm[$];
    fbit_t ql[$];

    always #5 clk = ~clk;

    concat_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
        .sout(m_sout), .sout_valid(m_valid), .frame_start(m_start), .frame_end(m_end),
        .busy(m_busy)
    );

    concat_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
        .sout(l_sout), .sout_valid(l_valid), .frame_start(l_start), .frame_end(l_end),
        .busy(l_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Bit i of a frame carrying word w, straight from the framing rules.
    function automatic fbit_t frame_bit(input logic [7:0] w, input bit msb, input int i);
        fbit_t f;
        if (i < 8) f.b = msb ? w[7-i] : w[i];
        else       f.b = ^w;
        f.s = (i == 0);
        f.e = (i == FLEN - 1);
        return f;
    endfunction

    function automatic logic [4:0] exp_out(input fbit_t head, input bit live);
        // {sout_valid, sout, frame_start, frame_end, busy}
        return live ? {1'b1, head.b, head.s, head.e, 1'b1} : 5'b0;
    endfunction

    // One clock: drive inputs, check ready, step the model at the edge, check registered outputs.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, output bit acc);
        bit exp_ready;
        rst       = r;
        din_valid = v;
        din       = d;
        #1;
        exp_ready = !r && (qm.size() <= 1);
        check("m_ready", m_ready, exp_ready);
        check("l_ready", l_ready, exp_ready);
        acc = v && exp_ready;
        @(posedge clk);
        if (qm.size() > 0) void'(qm.pop_front());
        if (ql.size() > 0) void'(ql.pop_front());
        if (r) begin
            qm.delete();
            ql.delete();
        end else if (acc) begin
            for (int i = 0; i < FLEN; i++) begin
                qm.push_back(frame_bit(d, 1'b1, i));
                ql.push_back(frame_bit(d, 1'b0, i));
            end
        end
        #1;
        check("m_out", {m_valid, m_sout, m_start, m_end, m_busy},
              exp_out(qm.size() > 0 ? qm[0] : fbit_t'(3'b0), qm.size() > 0));
        check("l_out", {l_valid, l_sout, l_start, l_end, l_busy},
              exp_out(ql.size() > 0 ? ql[0] : fbit_t'(3'b0), ql.size() > 0));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom), acc);
    endtask

    // Hold a word valid until it is accepted, bounded so a stuck ready cannot hang the run.
    task automatic send(input logic [7:0] w);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cycle(1'b0, 1'b1, w, acc);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit acc;
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        @(negedge clk);

        // Word offered during reset must be dropped.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hFF, acc);
        idle(2);

        // Single frame, then drain.
        send(8'b0011_0101);
        idle(FLEN + 1);

        // Back-to-back words; the second is held valid and taken on frame_end.
        send(8'b1111_1010);
        send(8'b0110_1101);
        idle(FLEN + 1);

        // Reset on cycle 4 of a frame, then a fresh word.
        send(8'hA5);
        idle(3);
        cycle(1'b1, 1'b0, 8'h00, acc);
        idle(2);
        send(8'h3C);
        idle(FLEN);

        // Stall with valid low.
        idle(5);

        // Random traffic, din wiggling mid-frame and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), 8'($urandom), acc);
        end
        idle(FLEN + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/concat_serializer.md
# concat_serializer

Downstream stage of the concatenation operator block: accepts the packed 8-bit concatenation results (e.g. `{a,b}`) over a valid/ready handshake and shifts each word out one bit per clock with frame markers. It turns parallel concatenated words into a serial stream for the pin-limited outputs of the operator demo. It supports back-to-back words with no idle cycle, MSB-first or LSB-first ordering, and an optional parity bit.

## Interface
- `DATA_W`, 8, word width in bits (≥2).
- `MSB_FIRST`, 1, 1 = shift out bit `DATA_W-1` first; 0 = bit 0 first.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  DATA_W  parallel word (concatenated value).
- `din_valid`  input  1  `din` is valid.
- `din_ready`  output  1  block can accept a word this cycle.
- `sout`  output  1  serial data bit.
- `sout_valid`  output  1  `sout` carries a frame bit this cycle.
- `frame_start`  output  1  high with the first bit of a frame.
- `frame_end`  output  1  high with the last bit of a frame (data or parity).
- `busy`  output  1  a frame is in progress.

Clock and reset are decided: one clock `clk`; `rst` is synchronous and active-high.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY only with the macro). Internal shift register `sr[DATA_W-1:0]`, bit counter `cnt` of width `$clog2(DATA_W)`, parity accumulator `par`.
- Accept: `din_valid && din_ready` at a rising edge.
  - Loads `sr <= din`, `cnt <= 0`, `par <= ^din`.
  - Moves to SHIFT.
- `din_ready` is combinational.
  - High in IDLE.
  - High on the final frame cycle: the last data bit without parity, or the PARITY cycle with parity.
  - Low otherwise, and forced low while `rst` is high.
- SHIFT:
  - `sout` = `sr[DATA_W-1]` (MSB_FIRST=1) or `sr[0]` (MSB_FIRST=0).
  - Each cycle, `sr` shifts toward the output end, zero-filling, and `cnt` increments.
  - At `cnt == DATA_W-1`:
    - With parity: go to PARITY.
    - Otherwise: on an accept, reload and stay in SHIFT; with no accept, go to IDLE.
- PARITY: `sout = par`, which is even parity (XOR of all data bits).
  - On an accept: reload and go to SHIFT.
  - With no accept: go to IDLE.
- `frame_start` = SHIFT && `cnt == 0`.
- `frame_end` = the final frame cycle.
- `busy` = state ≠ IDLE.
- `din` is sampled only on accept. Changes to `din` mid-frame have no effect.
- Reset mid-frame: the frame is abandoned and no further bits are emitted. The next cycle starts in IDLE with all outputs at their reset values.

## Timing
- Reset values: state = IDLE; `sr`, `cnt`, `par` = 0; `sout`, `sout_valid`, `frame_start`, `frame_end`, `busy` = 0. `din_ready` = 1 on the first cycle after `rst` deasserts.
- `sout`, `sout_valid`, `frame_start`, `frame_end`, `busy` are registered (state-decoded, glitch-free).
- Latency: the first bit appears in the cycle after the accept edge.
- Frame length is DATA_W cycles, or DATA_W+1 cycles with parity.
- Back-to-back: an accept on the `frame_end` cycle gives the next `frame_start` in the immediately following cycle, with zero gap.
- Simultaneous `rst` and accept: reset wins and the word is dropped (`din_ready` is 0 during reset).
- `din_valid` low in IDLE: outputs hold at idle values indefinitely.

## Configuration
- `CONCAT_SER_PARITY_EN` defined:
  - The PARITY state exists.
  - Each frame carries DATA_W data bits followed by one even-parity bit.
  - `frame_end` and `din_ready` assert on the parity cycle.
- Not defined:
  - The PARITY state and `par` logic are removed.
  - Frames are exactly DATA_W bits.
  - `frame_end` and `din_ready` assert on the last data bit.

## Test plan
- Reset check: hold `rst` for 3 cycles with `din_valid`=1 and `din`=8'hFF.
  - Required: all outputs 0 and `din_ready`=0 during reset.
  - Required: `din_ready`=1 on the first cycle after reset, and no frame is emitted for the word offered during reset.
- Single frame, MSB_FIRST=1, no parity: `din`=8'b0011_0101 accepted at cycle 0.
  - Required: `sout` = 0,0,1,1,0,1,0,1 on cycles 1–8.
  - Required: `frame_start` on cycle 1, `frame_end` on cycle 8, `busy` low on cycle 9.
- Back-to-back, MSB_FIRST=0: 8'b1111_1010, then 8'b0110_1101 held valid.
  - Required: first frame `sout` = 0,1,0,1,1,1,1,1.
  - Required: second frame starts the very next cycle with `sout` = 1,0,1,1,0,1,1,0, with no gap.
- Parity (macro defined): 8'b1111_1010 (six ones) gives parity bit 0; 8'b0110_1101 (five ones) gives parity bit 1.
  - Required: each frame is 9 cycles, and `frame_end` coincides with the parity bit.
- Mid-frame reset: assert `rst` on cycle 4 of a frame carrying 8'hA5.
  - Required: `sout_valid`=0 from cycle 5 onward.
  - Required: a fresh accept of 8'h3C afterwards serializes correctly from `frame_start`.
- Stall: `din_valid` low for 5 cycles after a frame.
  - Required: `busy`=0, `sout_valid`=0, `din_ready`=1 throughout, with no spurious `frame_start`.
